// File: rtl/decode_stage.sv
// decode_stage: RISC-V instruction decode with a two-entry skid buffer.
// Decode is combinational on the incoming instruction; the decoded entry is
// registered so results appear one cycle after acceptance. out_* always
// present the main entry; the skid entry absorbs one extra instruction when
// downstream stalls, so in_ready_o can be a plain register.
// Optional feature: define DECODE_STAGE_RV32M_EN to accept the M extension
// (OP opcode with funct7 = 0000001).
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  // funct7 values accepted on the OP (register-register) opcode.
  function automatic logic op_funct7_ok(input logic [6:0] f7);
`ifdef DECODE_STAGE_RV32M_EN
    return (f7 == 7'b0000000) || (f7 == 7'b0100000) || (f7 == 7'b0000001);
`else
    return (f7 == 7'b0000000) || (f7 == 7'b0100000);
`endif
  endfunction

  // Sign-extend a 32-bit immediate to the configured datapath width.
  function automatic logic [XLEN-1:0] sext_imm(input logic signed [31:0] v);
    logic signed [XLEN-1:0] r;
    r = XLEN'(v);
    return r;
  endfunction

  function automatic entry_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    entry_t            e;
    logic [2:0]        fmt;
    logic signed [31:0] imm32;
    fmt = FMT_ILL;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'b0110111, 7'b0010111:                                  fmt = FMT_U;
        7'b1101111:                                              fmt = FMT_J;
        7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: fmt = FMT_I;
        7'b0100011:                                              fmt = FMT_S;
        7'b1100011:                                              fmt = FMT_B;
        7'b0110011: fmt = op_funct7_ok(inst[31:25]) ? FMT_R : FMT_ILL;
        default:                                                 fmt = FMT_ILL;
      endcase
    end
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    e.pc      = pc;
    e.opcode  = inst[6:0];
    e.rd      = inst[11:7];
    e.rs1     = inst[19:15];
    e.rs2     = inst[24:20];
    e.funct3  = inst[14:12];
    e.funct7  = inst[31:25];
    e.imm     = sext_imm(imm32);
    e.fmt     = fmt;
    e.illegal = (fmt == FMT_ILL);
    return e;
  endfunction

  state_t state_p1, state_nxt;
  entry_t main_p1, skid_p1, dec_p0;
  logic   accept_p0, consume_p0;
  logic   load_main, load_skid, move_skid;

  assign dec_p0     = decode(inst_i, pc_i);
  assign accept_p0  = in_valid_i && in_ready_o && !flush_i;
  assign consume_p0 = out_valid_o && out_ready_i;

  // Next-state and buffer-write selection for the skid buffer.
  always_comb begin
    state_nxt = state_p1;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: if (accept_p0) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (accept_p0 && consume_p0) begin
            load_main = 1'b1;
          end else if (accept_p0) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (consume_p0) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (consume_p0) begin
          state_nxt = ONE;
          move_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Control registers: state plus registered valid/ready derived from it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_p1    <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      state_p1    <= state_nxt;
      out_valid_o <= (state_nxt != EMPTY);
      in_ready_o  <= (state_nxt != TWO);
    end
  end

  // Stage 0 -> 1: capture decoded entries; cleared on reset so outputs read 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (move_skid)      main_p1 <= skid_p1;
      else if (load_main) main_p1 <= dec_p0;
      if (load_skid)      skid_p1 <= dec_p0;
    end
  end

  assign pc_o      = main_p1.pc;
  assign opcode_o  = main_p1.opcode;
  assign rd_o      = main_p1.rd;
  assign rs1_o     = main_p1.rs1;
  assign rs2_o     = main_p1.rs2;
  assign funct3_o  = main_p1.funct3;
  assign funct7_o  = main_p1.funct7;
  assign imm_o     = main_p1.imm;
  assign fmt_o     = main_p1.fmt;
  assign illegal_o = main_p1.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate and PC width; legal values 32 and 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-high reset; the name is kept for codebase consistency, and a level of 1 at a rising edge resets the block.
REQ-004 in_valid_i  input  1  upstream instruction valid.
REQ-005 in_ready_o  output  1  block can accept an instruction this cycle.
REQ-006 inst_i  input  32  raw instruction.
REQ-007 pc_i  input  XLEN  PC of inst_i.
REQ-008 flush_i  input  1  discard all held and incoming instructions.
REQ-009 out_valid_o  output  1  decoded entry valid.
REQ-010 out_ready_i  input  1  downstream accepts entry.
REQ-011 pc_o  output  XLEN  PC of decoded entry.
REQ-012 opcode_o[7], rd_o[5], rs1_o[5], rs2_o[5], funct3_o[3], funct7_o[7]  outputs  raw fields: inst[6:0], [11:7], [19:15], [24:20], [14:12], [31:25].
REQ-013 imm_o  output  XLEN  sign-extended immediate for the entry's format; 0 for R-format.
REQ-014 fmt_o  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-015 illegal_o  output  1  entry is not a supported instruction.

Function
REQ-016 Accept condition: in_valid_i && in_ready_o && !flush_i. Consume condition: out_valid_o && out_ready_i.
REQ-017 Decode is combinational on inst_i; results are registered, giving 1-cycle latency from accept to out_valid_o=1.
REQ-018 Storage is a 2-entry skid buffer (main, skid) tracked by state EMPTY/ONE/TWO; out_* always reflect main.
REQ-019 EMPTY: accept -> ONE.
REQ-020 ONE: accept and consume -> ONE, with main reloaded.
REQ-021 ONE: accept without consume -> TWO, with the input written to skid.
REQ-022 ONE: consume without accept -> EMPTY.
REQ-023 TWO: consume -> ONE, with skid moved to main.
REQ-024 TWO: accept is impossible because in_ready_o=0.
REQ-025 in_ready_o is registered and equals (state != TWO); a zero-bubble stream is sustained while out_ready_i=1.
REQ-026 Entries leave in acceptance order; no entry is duplicated or dropped except by flush.
REQ-027 Opcode map: 0110111 and 0010111 map to U; 1101111 maps to J.
REQ-028 Opcode map: 1100111, 0000011, 0010011, 0001111 and 1110011 map to I.
REQ-029 Opcode map: 0100011 maps to S, 1100011 maps to B, and 0110011 maps to R.
REQ-030 illegal_o=1 and fmt_o=7 when: inst[1:0]!=11; the opcode is unlisted; or the opcode is 0110011 with funct7 not in {0000000, 0100000} (see REQ-037).
REQ-031 Immediates: I=inst[31:20]; S={inst[31:25],inst[11:7]}; B={inst[31],inst[7],inst[30:25],inst[11:8],0}; U={inst[31:12],12'b0}; J={inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended from inst[31] to XLEN. Illegal entries have imm_o=0.
REQ-032 flush_i=1: state becomes EMPTY and out_valid_o=0 at the next edge, in_ready_o=1 after it; the same-cycle input is dropped. Flush has priority over accept and consume.

Reset
REQ-033 On a reset edge: state=EMPTY, out_valid_o=0, in_ready_o=1, all data outputs 0 (fmt_o=0, illegal_o=0).
REQ-034 Reset overrides flush, accept and consume in the same cycle, and discards any entries held mid-operation.
REQ-035 The first accept is possible in the cycle after reset deasserts.

Configuration
REQ-036 The macro DECODE_STAGE_RV32M_EN controls M-extension acceptance.
REQ-037 With DECODE_STAGE_RV32M_EN defined, opcode 0110011 with funct7=0000001 is legal, fmt_o=0.
REQ-038 Without DECODE_STAGE_RV32M_EN, such an instruction is illegal, fmt_o=7, illegal_o=1.

Verification
REQ-039 Accept inst_i=0xFFF00093, pc_i=0x100 -> next cycle: out_valid_o=1, rd_o=1, rs1_o=0, imm_o=0xFFFFFFFF, fmt_o=1, pc_o=0x100.
REQ-040 Accept 0xFE208EE3 -> imm_o=0xFFFFFFFC, fmt_o=3, rs1_o=1, rs2_o=2. With XLEN=64, accept 0x800000B7 -> imm_o=0xFFFFFFFF80000000, fmt_o=4.
REQ-041 Hold out_ready_i=0 and offer 3 instructions A, B, C -> A and B are accepted, in_ready_o=0 and C is held. Raise out_ready_i -> outputs A, B, C in consecutive cycles.
REQ-042 Reach state TWO, then pulse flush_i for 1 cycle with in_valid_i=1 -> next cycle out_valid_o=0 and in_ready_o=1; the flushed input never appears at the output.
REQ-043 Accept 0x022081B3 -> with the macro, illegal_o=0 and fmt_o=0; without it, illegal_o=1 and fmt_o=7. Accept 0x00000000 -> illegal_o=1 in both builds.
REQ-044 Assert rst_n=1 for 1 cycle while in state TWO -> next cycle all outputs are at their REQ-033 values; a new instruction is accepted and decoded correctly afterwards.
